// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential shift/rotate unit.
package shift_pkg;

    localparam int SHIFT_MODE_W = 3;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        LLS = 3'd0,
        LAS = 3'd1,
        RLS = 3'd2,
        RAS = 3'd3,
        ROL = 3'd4,
        ROR = 3'd5
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    function automatic logic mode_legal(input logic [SHIFT_MODE_W-1:0] m);
        return (m <= 3'd5);
    endfunction

    function automatic logic mode_rotate(input logic [SHIFT_MODE_W-1:0] m);
        return (m == 3'd4) || (m == 3'd5);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k positions (0..STEP) and
// reports the last bit that left the word.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int KW   = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  shift_mode_e      mode,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic             left_s;
    logic             rot_s;
    logic [WIDTH-1:0] pad_s;
    logic [2*WIDTH:0] wide_s;

    // A spare bit beyond the data captures the last exiting bit; rotates pad with data itself.
    always_comb begin
        left_s = (mode == LLS) || (mode == LAS) || (mode == ROL);
        rot_s  = (mode == ROL) || (mode == ROR);
        pad_s  = rot_s ? data : {WIDTH{fill}};
        if (left_s) begin
            wide_s = {1'b0, data, pad_s} << k;
            result = wide_s[2*WIDTH-1:WIDTH];
            carry  = wide_s[2*WIDTH];
        end else begin
            wide_s = {pad_s, data, 1'b0} >> k;
            result = wide_s[WIDTH:1];
            carry  = wide_s[0];
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: accepts an operand in IDLE, shifts up to STEP
// positions per cycle in SHIFT, and holds the result in DONE until taken.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int OFFW = $clog2(WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [OFFW-1:0]         in_offset,
    input  logic [SHIFT_MODE_W-1:0] in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_carry,
    output logic                    out_zero,
    output logic                    out_err
);

    shift_state_e            state_r;
    shift_state_e            state_s;
    logic [OFFW-1:0]         rem_r;
    logic [OFFW-1:0]         rem_in_s;
    logic [OFFW-1:0]         k_s;
    logic [WIDTH-1:0]        data_r;
    logic                    carry_r;
    logic                    zero_r;
    logic                    err_r;
    logic                    fill_r;
    logic [SHIFT_MODE_W-1:0] mode_r;
    logic [WIDTH-1:0]        step_data_s;
    logic                    step_carry_s;

    // Remaining count at accept: shifts saturate at WIDTH+1, rotates wrap modulo WIDTH.
    always_comb begin
        if (!mode_legal(in_mode)) begin
            rem_in_s = {OFFW{1'b0}};
        end else if (mode_rotate(in_mode)) begin
            rem_in_s = in_offset & OFFW'(WIDTH - 1);
        end else if (in_offset > OFFW'(WIDTH + 1)) begin
            rem_in_s = OFFW'(WIDTH + 1);
        end else begin
            rem_in_s = in_offset;
        end
    end

    // Step size for this cycle.
    always_comb begin
        if (rem_r < OFFW'(STEP)) begin
            k_s = rem_r;
        end else begin
            k_s = OFFW'(STEP);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data   (data_r),
        .k      (k_s),
        .mode   (shift_mode_e'(mode_r)),
        .fill   (fill_r),
        .result (step_data_s),
        .carry  (step_carry_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (!mode_legal(in_mode) || (rem_in_s == {OFFW{1'b0}})) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r == k_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand latch and per-cycle shift datapath; results hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            err_r   <= 1'b0;
            fill_r  <= 1'b0;
            mode_r  <= {SHIFT_MODE_W{1'b0}};
            rem_r   <= {OFFW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r  <= in_data;
                        zero_r  <= (in_data == {WIDTH{1'b0}});
                        carry_r <= 1'b0;
                        err_r   <= !mode_legal(in_mode);
                        fill_r  <= (in_mode == RAS) ? in_data[WIDTH-1] : 1'b0;
                        mode_r  <= in_mode;
                        rem_r   <= rem_in_s;
                    end
                end
                SHIFT: begin
                    data_r  <= step_data_s;
                    zero_r  <= (step_data_s == {WIDTH{1'b0}});
                    carry_r <= step_carry_s;
                    rem_r   <= rem_r - k_s;
                end
                default: begin
                    rem_r <= rem_r;
                end
            endcase
        end
    end

    assign out_data  = data_r;
    assign out_carry = carry_r;
    assign out_zero  = zero_r;
    assign out_err   = err_r;

endmodule
